jtkiwi_subctl: RTL and testbench

- Parametrised bus controller for the sub (sound) Z80.
- Functions: address decode to registered chip selects, banked ROM address generation, bank/MCU-reset latch, VBLANK interrupt latch with configurable acknowledge, N-port cabinet input mux, registered read-data mux, and a frame-count watchdog.
- Sits between the sub Z80 and the ROM, shared RAM, FM chip and cabinet inputs. CPU, FM chip and mixer are instantiated outside.

---
 rtl/jtkiwi_subctl_if.sv | 14 +
 rtl/jtkiwi_subctl.sv | 168 ++++++++++++++++
 tb/tb_jtkiwi_subctl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtkiwi_subctl_if.sv
// Sub Z80 bus bundle: address, strobes and data in both directions.
interface jtkiwi_subctl_if;
  logic [15:0] A;
  logic        mreq_n;
  logic        rfsh_n;
  logic        iorq_n;
  logic        m1_n;
  logic        wr_n;
  logic [7:0]  dout;
  logic [7:0]  din;

  modport master (output A, mreq_n, rfsh_n, iorq_n, m1_n, wr_n, dout, input din);
  modport slave  (input  A, mreq_n, rfsh_n, iorq_n, m1_n, wr_n, dout, output din);
endinterface

// File: rtl/jtkiwi_subctl.sv
// Sub (sound) Z80 bus controller: decode, banked ROM, IRQ latch, cabinet mux.
// Optional frame watchdog built when JTKIWI_SUBCTL_WDOG_EN is defined.
module jtkiwi_subctl #(
  parameter int unsigned BANKW       = 2,
  parameter int unsigned NCAB        = 3,
  parameter logic [7:0]  CAB_DEF     = 8'h00,
  parameter int unsigned ACK_M1      = 0,
  parameter int unsigned WDOG_FRAMES = 8,
  parameter int unsigned WDOG_PULSE  = 16,
  localparam int unsigned RAW        = 13 + BANKW
) (
  input  logic              clk,
  input  logic              comb_rstn,
  jtkiwi_subctl_if.slave    cpu,
  input  logic              LVBL,
  input  logic [7:0]        rom_data,
  input  logic [7:0]        ram_dout,
  input  logic [7:0]        fm_dout,
  input  logic [8*NCAB-1:0] cab_in,
  output logic [RAW-1:0]    rom_addr,
  output logic              rom_cs,
  output logic              fm_cs,
  output logic              ram_cs,
  output logic              bank_cs,
  output logic [BANKW-1:0]  bank,
  output logic              mcu_rst,
  output logic              int_n,
  output logic              wdog_rst
);

  logic       mem_acc;
  logic       cab_cs;
  logic [7:0] cab_dout;
  logic [7:0] din_r;
  logic [7:0] cab_arr [8];
  logic       lvbl_l, lvbl_ll;
  logic       vb_edge;
  logic       ack;
  logic       unused_bits;

  assign mem_acc     = ~cpu.mreq_n & cpu.rfsh_n;
  assign cpu.din     = din_r;
  assign unused_bits = ^cpu.dout;

  // Upper half of the CPU map is a window into the banked ROM pages
  always_comb begin
    rom_addr = RAW'(cpu.A[14:0]);
    if (cpu.A[15]) rom_addr = {bank, cpu.A[12:0]};
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      rom_cs  <= 1'b0;
      bank_cs <= 1'b0;
      fm_cs   <= 1'b0;
      cab_cs  <= 1'b0;
      ram_cs  <= 1'b0;
    end else begin
      rom_cs  <= mem_acc && (cpu.A[15:12] < 4'hA);
      bank_cs <= mem_acc && (cpu.A[15:12] == 4'hA);
      fm_cs   <= mem_acc && (cpu.A[15:12] == 4'hB);
      cab_cs  <= mem_acc && (cpu.A[15:12] == 4'hC);
      ram_cs  <= mem_acc && (cpu.A[15:12] == 4'hD || cpu.A[15:12] == 4'hE);
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      bank    <= '0;
      mcu_rst <= 1'b0;
    end else if (bank_cs && !cpu.wr_n) begin
      bank    <= cpu.dout[BANKW-1:0];
      mcu_rst <= cpu.dout[BANKW];
    end
  end

  // Unpopulated cabinet indexes read back as CAB_DEF
  for (genvar k = 0; k < 8; k++) begin : g_cab
    if (k < NCAB) begin : g_real
      assign cab_arr[k] = cab_in[8*k +: 8];
    end else begin : g_def
      assign cab_arr[k] = CAB_DEF;
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      cab_dout <= 8'h00;
      din_r    <= 8'h00;
    end else begin
      cab_dout <= cab_arr[cpu.A[2:0]];
      if      (rom_cs) din_r <= rom_data;
      else if (ram_cs) din_r <= ram_dout;
      else if (fm_cs)  din_r <= fm_dout;
      else if (cab_cs) din_r <= cab_dout;
      else             din_r <= 8'h00;
    end
  end

  assign vb_edge = lvbl_ll & ~lvbl_l;
  assign ack     = ~cpu.iorq_n & ((ACK_M1 != 0) ? ~cpu.m1_n : 1'b1);

  // A new frame edge takes precedence over a simultaneous acknowledge
  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      lvbl_l  <= 1'b0;
      lvbl_ll <= 1'b0;
      int_n   <= 1'b1;
    end else begin
      lvbl_l  <= LVBL;
      lvbl_ll <= lvbl_l;
      if      (vb_edge) int_n <= 1'b0;
      else if (ack)     int_n <= 1'b1;
    end
  end

`ifdef JTKIWI_SUBCTL_WDOG_EN
  localparam int unsigned FW = 8;
  localparam int unsigned PW = $clog2(WDOG_PULSE + 1);

  typedef enum logic {RUN, FIRE} wdog_st_t;

  wdog_st_t       wdog_st;
  logic [FW-1:0]  fcnt;
  logic [PW-1:0]  pcnt;

  // Frames without a bank access trigger a fixed-length reset pulse
  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      wdog_st  <= RUN;
      fcnt     <= '0;
      pcnt     <= '0;
      wdog_rst <= 1'b0;
    end else begin
      case (wdog_st)
        RUN: begin
          if (bank_cs) begin
            fcnt <= '0;
          end else if (vb_edge) begin
            if (fcnt == FW'(WDOG_FRAMES - 1)) begin
              wdog_st  <= FIRE;
              pcnt     <= PW'(WDOG_PULSE);
              fcnt     <= '0;
              wdog_rst <= 1'b1;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
        end
        FIRE: begin
          pcnt <= pcnt - PW'(1);
          if (pcnt == PW'(1)) begin
            wdog_st  <= RUN;
            wdog_rst <= 1'b0;
          end
        end
        default: begin
          wdog_st  <= RUN;
          wdog_rst <= 1'b0;
        end
      endcase
    end
  end
`else
  assign wdog_rst = 1'b0;
`endif

endmodule

// File: tb/tb_jtkiwi_subctl.sv
// Directed bench for jtkiwi_subctl; watchdog scenarios follow JTKIWI_SUBCTL_WDOG_EN.
module tb_jtkiwi_subctl;

  logic        clk = 1'b0;
  logic        comb_rstn;
  logic        LVBL;
  logic [7:0]  rom_data, ram_dout, fm_dout;
  logic [23:0] cab_in;
  logic [14:0] rom_addr;
  logic        rom_cs, fm_cs, ram_cs, bank_cs;
  logic [1:0]  bank;
  logic        mcu_rst, int_n, wdog_rst;

  int checks   = 0;
  int failures = 0;
  int wdog_hi  = 0;
  int base;

  jtkiwi_subctl_if bus();

  jtkiwi_subctl #(
    .BANKW(2), .NCAB(3), .CAB_DEF(8'h00), .ACK_M1(1),
    .WDOG_FRAMES(4), .WDOG_PULSE(16)
  ) dut (
    .clk(clk), .comb_rstn(comb_rstn), .cpu(bus), .LVBL(LVBL),
    .rom_data(rom_data), .ram_dout(ram_dout), .fm_dout(fm_dout), .cab_in(cab_in),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .fm_cs(fm_cs), .ram_cs(ram_cs),
    .bank_cs(bank_cs), .bank(bank), .mcu_rst(mcu_rst), .int_n(int_n),
    .wdog_rst(wdog_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wdog_rst === 1'b1) wdog_hi <= wdog_hi + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vb_edge;
    LVBL = 1'b0; tick(2);
    LVBL = 1'b1; tick(2);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    comb_rstn = 1'b0; LVBL = 1'b1;
    bus.A = 16'h0000; bus.mreq_n = 1'b1; bus.rfsh_n = 1'b1; bus.iorq_n = 1'b1;
    bus.m1_n = 1'b1; bus.wr_n = 1'b1; bus.dout = 8'h00;
    rom_data = 8'h00; ram_dout = 8'h00; fm_dout = 8'h00; cab_in = 24'hC3B2A1;
    #23;
    if (bus.din !== 8'h00) begin failures++; $display("FAIL rst_din got=%0h exp=0", bus.din); end
    checks++;
    if ({rom_cs, fm_cs, ram_cs, bank_cs} !== 4'b0000) begin
      failures++; $display("FAIL rst_cs got=%0b exp=0000", {rom_cs, fm_cs, ram_cs, bank_cs});
    end
    checks++;
    if ({bank, mcu_rst, int_n, wdog_rst} !== 5'b00010) begin
      failures++; $display("FAIL rst_state got=%0b exp=00010", {bank, mcu_rst, int_n, wdog_rst});
    end
    checks++;
    @(negedge clk) comb_rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_bank;
    bus.A = 16'hA000; bus.dout = 8'h07; bus.wr_n = 1'b0; bus.mreq_n = 1'b0;
    tick(2);
    if (bank !== 2'd3) begin failures++; $display("FAIL bank_wr got=%0h exp=3", bank); end
    checks++;
    if (mcu_rst !== 1'b1) begin failures++; $display("FAIL mcu_rst got=%0b exp=1", mcu_rst); end
    checks++;
    bus.wr_n = 1'b1; bus.dout = 8'h00; bus.A = 16'h8123;
    #1;
    if (rom_addr !== 15'h6123) begin failures++; $display("FAIL rom_addr_bank got=%0h exp=6123", rom_addr); end
    checks++;
    tick(1);
    if (rom_cs !== 1'b1) begin failures++; $display("FAIL rom_cs got=%0b exp=1", rom_cs); end
    checks++;
    bus.A = 16'h1234;
    #1;
    if (rom_addr !== 15'h1234) begin failures++; $display("FAIL rom_addr_low got=%0h exp=1234", rom_addr); end
    checks++;
    bus.A = 16'hA000;
    tick(2);
    if (bank_cs !== 1'b1) begin failures++; $display("FAIL bank_cs_rd got=%0b exp=1", bank_cs); end
    checks++;
    if ({bank, mcu_rst} !== 3'b111) begin failures++; $display("FAIL bank_rd_keep got=%0b exp=111", {bank, mcu_rst}); end
    checks++;
    bus.A = 16'hB005; fm_dout = 8'h77;
    tick(2);
    if ({fm_cs, bus.din} !== {1'b1, 8'h77}) begin failures++; $display("FAIL fm_read got=%0h exp=177", {fm_cs, bus.din}); end
    checks++;
    bus.A = 16'h1234; rom_data = 8'h5A;
    tick(2);
    if (bus.din !== 8'h5A) begin failures++; $display("FAIL rom_read got=%0h exp=5a", bus.din); end
    checks++;
    bus.A = 16'hE010; ram_dout = 8'h3C;
    tick(2);
    if ({ram_cs, bus.din} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL ram_read got=%0h exp=13c", {ram_cs, bus.din}); end
    checks++;
    bus.A = 16'hF000;
    tick(2);
    if ({rom_cs, fm_cs, ram_cs, bank_cs, bus.din} !== 12'h000) begin
      failures++; $display("FAIL f_page got=%0h exp=0", {rom_cs, fm_cs, ram_cs, bank_cs, bus.din});
    end
    checks++;
    bus.mreq_n = 1'b1;
    tick(2);
  endtask

  task automatic test_irq;
    LVBL = 1'b0;
    tick(1);
    if (int_n !== 1'b1) begin failures++; $display("FAIL irq_early got=%0b exp=1", int_n); end
    checks++;
    tick(1);
    if (int_n !== 1'b0) begin failures++; $display("FAIL irq_set got=%0b exp=0", int_n); end
    checks++;
    bus.iorq_n = 1'b0; bus.m1_n = 1'b1;
    tick(2);
    if (int_n !== 1'b0) begin failures++; $display("FAIL irq_no_m1 got=%0b exp=0", int_n); end
    checks++;
    bus.m1_n = 1'b0;
    tick(1);
    if (int_n !== 1'b1) begin failures++; $display("FAIL irq_ack got=%0b exp=1", int_n); end
    checks++;
    bus.iorq_n = 1'b1; bus.m1_n = 1'b1; LVBL = 1'b1;
    tick(3);
    LVBL = 1'b0; bus.iorq_n = 1'b0; bus.m1_n = 1'b0;
    tick(2);
    bus.iorq_n = 1'b1; bus.m1_n = 1'b1;
    tick(1);
    if (int_n !== 1'b0) begin failures++; $display("FAIL irq_set_wins got=%0b exp=0", int_n); end
    checks++;
    LVBL = 1'b1; bus.iorq_n = 1'b0; bus.m1_n = 1'b0;
    tick(1);
    bus.iorq_n = 1'b1; bus.m1_n = 1'b1;
    tick(2);
  endtask

  task automatic test_cab;
    bus.A = 16'hC000; bus.mreq_n = 1'b0;
    tick(1);
    if (bus.din !== 8'h00) begin failures++; $display("FAIL cab_lat got=%0h exp=0", bus.din); end
    checks++;
    tick(1);
    if (bus.din !== 8'hA1) begin failures++; $display("FAIL cab0 got=%0h exp=a1", bus.din); end
    checks++;
    bus.A = 16'hC001;
    tick(2);
    if (bus.din !== 8'hB2) begin failures++; $display("FAIL cab1 got=%0h exp=b2", bus.din); end
    checks++;
    bus.A = 16'hC002;
    tick(2);
    if (bus.din !== 8'hC3) begin failures++; $display("FAIL cab2 got=%0h exp=c3", bus.din); end
    checks++;
    bus.A = 16'hC005;
    tick(2);
    if (bus.din !== 8'h00) begin failures++; $display("FAIL cab_def got=%0h exp=0", bus.din); end
    checks++;
    bus.mreq_n = 1'b1;
    tick(2);
  endtask

`ifdef JTKIWI_SUBCTL_WDOG_EN
  task automatic test_wdog;
    bus.A = 16'hA000; bus.mreq_n = 1'b0;
    tick(2);
    bus.mreq_n = 1'b1;
    tick(2);
    base = wdog_hi;
    repeat (4) vb_edge;
    tick(25);
    if (wdog_hi - base != 16) begin failures++; $display("FAIL wdog_pulse got=%0d exp=16", wdog_hi - base); end
    checks++;
    base = wdog_hi;
    repeat (3) vb_edge;
    bus.A = 16'hA000; bus.mreq_n = 1'b0;
    tick(2);
    bus.mreq_n = 1'b1;
    tick(2);
    repeat (3) vb_edge;
    tick(5);
    if (wdog_hi - base != 0) begin failures++; $display("FAIL wdog_kick got=%0d exp=0", wdog_hi - base); end
    checks++;
    vb_edge;
    tick(25);
    if (wdog_hi - base != 16) begin failures++; $display("FAIL wdog_after_kick got=%0d exp=16", wdog_hi - base); end
    checks++;
  endtask
`else
  task automatic test_nowdog;
    base = wdog_hi;
    repeat (20) vb_edge;
    tick(5);
    if (wdog_hi - base != 0) begin failures++; $display("FAIL nowdog_cycles got=%0d exp=0", wdog_hi - base); end
    checks++;
    if (wdog_rst !== 1'b0) begin failures++; $display("FAIL nowdog_level got=%0b exp=0", wdog_rst); end
    checks++;
  endtask
`endif

  task automatic test_reset_mid;
    bus.A = 16'hA000; bus.dout = 8'h07; bus.wr_n = 1'b0; bus.mreq_n = 1'b0;
    tick(2);
    bus.wr_n = 1'b1; bus.dout = 8'h00; bus.A = 16'h1234; rom_data = 8'h5A;
    tick(2);
`ifdef JTKIWI_SUBCTL_WDOG_EN
    repeat (4) vb_edge;
    if (wdog_rst !== 1'b1) begin failures++; $display("FAIL mid_fire got=%0b exp=1", wdog_rst); end
    checks++;
`else
    vb_edge;
`endif
    if ({int_n, bank, bus.din} !== {1'b0, 2'd3, 8'h5A}) begin
      failures++; $display("FAIL mid_pre got=%0h exp=35a", {int_n, bank, bus.din});
    end
    checks++;
    #3 comb_rstn = 1'b0;
    #2;
    if ({wdog_rst, int_n, bank, mcu_rst} !== 5'b01000) begin
      failures++; $display("FAIL mid_rst_state got=%0b exp=01000", {wdog_rst, int_n, bank, mcu_rst});
    end
    checks++;
    if ({rom_cs, bus.din} !== 9'h000) begin failures++; $display("FAIL mid_rst_din got=%0h exp=0", {rom_cs, bus.din}); end
    checks++;
    @(negedge clk) comb_rstn = 1'b1;
    tick(1);
`ifdef JTKIWI_SUBCTL_WDOG_EN
    base = wdog_hi;
    repeat (3) vb_edge;
    tick(3);
    if (wdog_hi - base != 0) begin failures++; $display("FAIL mid_restart got=%0d exp=0", wdog_hi - base); end
    checks++;
    vb_edge;
    tick(25);
    if (wdog_hi - base != 16) begin failures++; $display("FAIL mid_refire got=%0d exp=16", wdog_hi - base); end
    checks++;
`endif
    bus.mreq_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_bank();
    test_irq();
    test_cab();
`ifdef JTKIWI_SUBCTL_WDOG_EN
    test_wdog();
`else
    test_nowdog();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
